pipe_rca_adder: RTL and testbench

//  Parametrised, pipelined ripple-carry adder: WIDTH-bit A+B+Cin split into STAGE_W-bit

---
 rtl/rca_pkg.sv | 15 +
 rtl/rca_chunk.sv | 42 ++++
 rtl/pipe_rca_adder.sv | 136 +++++++++++++
 tb/tb_pipe_rca_adder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared constants and configuration checks for the pipelined ripple-carry adder.
// Contents:
//   DEF_WIDTH   - default operand/sum width
//   DEF_STAGE_W - default bits added per pipeline stage
//   width_ok()  - legality of a WIDTH/STAGE_W pairing, used for the elaboration check
package rca_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_STAGE_W = 4;

  function automatic bit width_ok(input int width, input int stage_w);
    return (stage_w > 0) && (width >= stage_w) && ((width % stage_w) == 0);
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// STAGE_W-bit combinational ripple-carry adder built from full_adder_1 cells.
// Ports:
//   a, b   [STAGE_W-1:0]  chunk operands
//   cin                   carry into bit 0
//   sum    [STAGE_W-1:0]  chunk sum
//   carry  [STAGE_W:0]    full carry chain; carry[0]=cin, carry[i+1]=carry out of bit i.
//                         carry[STAGE_W] is the chunk carry out, carry[STAGE_W-1] the
//                         carry into the top bit (needed for signed overflow).
module full_adder_1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module rca_chunk
  import rca_pkg::*;
#(
  parameter int STAGE_W = DEF_STAGE_W
) (
  input  logic [STAGE_W-1:0] a,
  input  logic [STAGE_W-1:0] b,
  input  logic               cin,
  output logic [STAGE_W-1:0] sum,
  output logic [STAGE_W:0]   carry
);
  assign carry[0] = cin;

  for (genvar i = 0; i < STAGE_W; i++) begin : g_bit
    full_adder_1 u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end
endmodule

// File: rtl/pipe_rca_adder.sv
// Pipelined ripple-carry adder with valid/ready streaming.
// WIDTH-bit A+B+Cin is split into STAGE_W-bit chunks, one chunk per pipeline stage,
// with the carry registered between stages. Latency is STAGES = WIDTH/STAGE_W cycles.
// Optional feature: define PIPE_RCA_OVF_EN to add the registered signed-overflow port ovf.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake; in_ready = !out_valid || out_ready
//   a, b, cin            operands and carry-in
//   out_valid/out_ready  output handshake
//   sum, cout            registered result, held while out_valid && !out_ready
//   ovf                  signed overflow (PIPE_RCA_OVF_EN only)
module pipe_rca_adder
  import rca_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int STAGE_W = DEF_STAGE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_RCA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = WIDTH / STAGE_W;

  if (!width_ok(WIDTH, STAGE_W)) begin : g_bad_cfg
    $fatal(1, "pipe_rca_adder: WIDTH must be a positive multiple of STAGE_W");
  end

  // One global enable: the whole pipe moves or holds together, bubbles included.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still unconsumed on entry to stage k (its own chunk and above).
    localparam int REM = WIDTH - k * STAGE_W;

    logic [REM-1:0]             a_in;
    logic [REM-1:0]             b_in;
    logic                       c_in;
    logic                       v_in;
    logic [STAGE_W-1:0]         s_chunk;
    logic [STAGE_W:0]           chain;
    logic [(k+1)*STAGE_W-1:0]   sum_next;
    logic [(k+1)*STAGE_W-1:0]   sum_r;
    logic                       v_r;
    logic                       c_r;
    logic                       unused_chain;

    if (k == 0) begin : g_src
      assign a_in     = a;
      assign b_in     = b;
      assign c_in     = cin;
      assign v_in     = in_valid;
      assign sum_next = s_chunk;
    end else begin : g_src
      assign a_in     = g_stage[k-1].g_fwd.a_r;
      assign b_in     = g_stage[k-1].g_fwd.b_r;
      assign c_in     = g_stage[k-1].c_r;
      assign v_in     = g_stage[k-1].v_r;
      // Completed lower chunks ride along so the sum is aligned at the output.
      assign sum_next = {s_chunk, g_stage[k-1].sum_r};
    end

    rca_chunk #(.STAGE_W(STAGE_W)) u_chunk (
      .a     (a_in[STAGE_W-1:0]),
      .b     (b_in[STAGE_W-1:0]),
      .cin   (c_in),
      .sum   (s_chunk),
      .carry (chain)
    );

    // Only the chunk carry out is pipelined; inner chain bits matter for ovf alone.
    assign unused_chain = ^chain[STAGE_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_r   <= 1'b0;
        c_r   <= 1'b0;
        sum_r <= '0;
      end else if (advance) begin
        v_r   <= v_in;
        c_r   <= chain[STAGE_W];
        sum_r <= sum_next;
      end
    end

    // Skew registers: upper operand chunks wait here until their stage uses them.
    if (REM > STAGE_W) begin : g_fwd
      logic [REM-STAGE_W-1:0] a_r;
      logic [REM-STAGE_W-1:0] b_r;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_r <= '0;
          b_r <= '0;
        end else if (advance) begin
          a_r <= a_in[REM-1:STAGE_W];
          b_r <= b_in[REM-1:STAGE_W];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_r;
  assign sum       = g_stage[STAGES-1].sum_r;
  assign cout      = g_stage[STAGES-1].c_r;

`ifdef PIPE_RCA_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of the MSB.
  logic ovf_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (advance) begin
      ovf_r <= g_stage[STAGES-1].chain[STAGE_W] ^ g_stage[STAGES-1].chain[STAGE_W-1];
    end
  end

  assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_pipe_rca_adder.sv
module tb_pipe_rca_adder;

  localparam int WIDTH   = 16;
  localparam int STAGE_W = 4;
  localparam int STAGES  = WIDTH / STAGE_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef PIPE_RCA_OVF_EN
  logic             ovf;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   rand_ready = 0;

  pipe_rca_adder #(.WIDTH(WIDTH), .STAGE_W(STAGE_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PIPE_RCA_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain wide arithmetic plus the signed-overflow sign rule.
  function automatic exp_t model(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                 input logic vc);
    exp_t e;
    logic [WIDTH:0] t;
    t      = {1'b0, va} + {1'b0, vb} + {{WIDTH{1'b0}}, vc};
    e.sum  = t[WIDTH-1:0];
    e.cout = t[WIDTH];
    e.ovf  = (va[WIDTH-1] == vb[WIDTH-1]) && (t[WIDTH-1] != va[WIDTH-1]);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issued at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                      input logic vc, input exp_t e);
    int n;
    bit ok;
    n  = 0;
    ok = 0;
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (ok) sb.push_back(e);
    else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat a=0x%0h not accepted in %0d cycles", va, n);
    end
  endtask

  task automatic send_rand();
    logic [WIDTH-1:0] va, vb;
    logic vc;
    va = WIDTH'($urandom);
    vb = WIDTH'($urandom);
    vc = 1'($urandom);
    send(va, vb, vc, model(va, vb, vc));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, sb.size(), 0);
  endtask

  // Monitor: a transfer happens at the next edge when out_valid && out_ready.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: sum=0x%0h with empty scoreboard", sum);
      end else begin
        e = sb.pop_front();
        check("sum", sum, e.sum);
        check("cout", cout, e.cout);
`ifdef PIPE_RCA_OVF_EN
        check("ovf", ovf, e.ovf);
`endif
        pop_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int base, c0, lat;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_sum", sum, 0);
    check("reset_cout", cout, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: driven just after edge 0, result visible after edge STAGES
    e.sum = 16'h2345; e.cout = 1'b0; e.ovf = 1'b0;
    a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    sb.push_back(e);
    lat = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, STAGES);
    drain("drain_first");

    // Full carry ripple and signed overflow corners
    e.sum = 16'h0000; e.cout = 1'b1; e.ovf = 1'b0;
    send(16'hFFFF, 16'h0000, 1'b1, e);
    e.sum = 16'h8000; e.cout = 1'b0; e.ovf = 1'b1;
    send(16'h7FFF, 16'h0001, 1'b0, e);
    e.sum = 16'h0000; e.cout = 1'b1; e.ovf = 1'b0;
    send(16'hFFFF, 16'h0001, 1'b0, e);
    e.sum = 16'h0000; e.cout = 1'b1; e.ovf = 1'b1;
    send(16'h8000, 16'h8000, 1'b0, e);
    drain("drain_corners");

    // 8 back-to-back beats, results on consecutive cycles
    base = pop_cyc.size();
    c0 = cyc;
    for (int i = 0; i < 8; i++) send_rand();
    check("burst_accept_cycles", cyc - c0, 8);
    drain("drain_burst");
    for (int i = 1; i < 8; i++)
      check("burst_consecutive", pop_cyc[base+i] - pop_cyc[base+i-1], 1);

    // Stall with pipe full
    out_ready = 1'b0;
    for (int i = 0; i < STAGES; i++) send_rand();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_sum_held", sum, sb[0].sum);
      check("stall_cout_held", cout, sb[0].cout);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send_rand();
    drain("drain_stall");

    // Reset with 3 beats in flight
    for (int i = 0; i < 3; i++) send_rand();
    #2 rst_n = 1'b0;
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_sum", sum, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("postreset_no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;

    // Random traffic with random backpressure and bubbles
    rand_ready = 1;
    fork
      begin
        while (rand_ready) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_rand();
    end
    rand_ready = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain("drain_random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
